// File: rtl/nettlp_bar0_regs.sv
`default_nettype none
// ============================================================================
// Module   : nettlp_bar0_regs
// Purpose  : BAR0 register target for the NetTLP adapter. It sits on the RX
//            AXI-Stream of the 7-series PCIe core and decodes single-DW 32-bit
//            MWr and MRd TLPs. It holds the adapter_reg_* encapsulation
//            settings used by the Ethernet side. MRd requests are answered
//            with a CplD on the shared TX stream, through the req/ack arbiter.
// Ports    : user_clk, user_reset       - clock and async active-high reset
//            cfg_*_number               - completer ID {bus, dev, func}
//            m_axis_rx_*                - inbound TLP stream (tuser[2]=BAR0)
//            s_axis_tx_req/ack          - TX arbitration handshake
//            s_axis_tx_*                - outbound completion stream
//            adapter_reg_*              - register contents
// Revision : 1.0 - initial release
// ============================================================================
module nettlp_bar0_regs #(
  parameter int          C_DATA_WIDTH = 64,              // only 64 supported
  parameter int          KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter logic [31:0] ID_VALUE     = 32'h4E54_0100
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [7:0]              cfg_bus_number,
  input  logic [4:0]              cfg_device_number,
  input  logic [2:0]              cfg_function_number,
  // RX TLP stream
  input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  input  logic [21:0]             m_axis_rx_tuser,
  // TX completion stream
  output logic                    s_axis_tx_req,
  input  logic                    s_axis_tx_ack,
  input  logic                    s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic                    s_axis_tx_tlast,
  output logic                    s_axis_tx_tvalid,
  output logic [3:0]              s_axis_tx_tuser,
  // Register contents
  output logic [31:0]             adapter_reg_magic,
  output logic [47:0]             adapter_reg_dstmac,
  output logic [47:0]             adapter_reg_srcmac,
  output logic [31:0]             adapter_reg_dstip,
  output logic [31:0]             adapter_reg_srcip,
  output logic [15:0]             adapter_reg_dstport,
  output logic [15:0]             adapter_reg_srcport
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DROP = 3'd2,
    ST_REQ  = 3'd3,
    ST_CPL0 = 3'd4,
    ST_CPL1 = 3'd5
  } state_t;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  state_t state_q, state_d;

  // Register file
  logic [31:0] magic_q,   magic_d;
  logic [47:0] dstmac_q,  dstmac_d;
  logic [47:0] srcmac_q,  srcmac_d;
  logic [31:0] dstip_q,   dstip_d;
  logic [31:0] srcip_q,   srcip_d;
  logic [15:0] dstport_q, dstport_d;
  logic [15:0] srcport_q, srcport_d;

  // Header fields captured from beat 0, used for execution and completion
  logic        is_wr_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [3:0]  first_be_q;
  // Read result and lower address captured from beat 1
  logic [31:0] rdata_q;
  logic [6:0]  addr_lo_q;

  // --------------------------------------------------------------------------
  // RX decode
  // --------------------------------------------------------------------------
  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_beat0;
  logic        w_beat1;
  logic        w_wr_en;
  logic        w_rd_cap;
  logic [31:0] w_dw0;
  logic [31:0] w_dw1;
  logic        w_is_mwr;
  logic        w_is_mrd;
  logic        w_hdr_ok;
  logic [5:0]  w_idx;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_val;
  logic [31:0] w_merged;

  // Held low while in reset so that nothing upstream sees a bogus accept.
  assign w_rx_ready = ~user_reset &
                      ((state_q == ST_IDLE) | (state_q == ST_HDR) | (state_q == ST_DROP));
  assign m_axis_rx_tready = w_rx_ready;

  assign w_rx_fire = m_axis_rx_tvalid & w_rx_ready;
  assign w_beat0   = (state_q == ST_IDLE) & w_rx_fire;
  assign w_beat1   = (state_q == ST_HDR) & w_rx_fire;

  assign w_dw0    = m_axis_rx_tdata[31:0];
  assign w_dw1    = m_axis_rx_tdata[63:32];
  assign w_is_mwr = (w_dw0[30:29] == FMT_3DW_DATA)   && (w_dw0[28:24] == TYPE_MEM);
  assign w_is_mrd = (w_dw0[30:29] == FMT_3DW_NODATA) && (w_dw0[28:24] == TYPE_MEM);
  assign w_hdr_ok = (w_is_mwr | w_is_mrd) && (w_dw0[9:0] == 10'd1) && m_axis_rx_tuser[2];

  // Beat 1 carries the address in the low DW and, for MWr, the payload above.
  assign w_idx   = m_axis_rx_tdata[7:2];
  assign w_wdata = m_axis_rx_tdata[63:32];

  // A beat 1 without tlast is malformed: it is dropped with no side effect.
  assign w_wr_en  = w_beat1 & m_axis_rx_tlast & is_wr_q;
  assign w_rd_cap = w_beat1 & m_axis_rx_tlast & ~is_wr_q;

  // Read view of the register at the beat-1 address. It also serves as the
  // "old" word for byte-enable merging, so partial writes keep untouched
  // bytes and any bits above a field's width fall away naturally.
  always_comb begin
    w_rd_val = 32'h0;
    case (w_idx)
      6'd0:    w_rd_val = magic_q;
      6'd1:    w_rd_val = {16'h0, dstmac_q[47:32]};
      6'd2:    w_rd_val = dstmac_q[31:0];
      6'd3:    w_rd_val = {16'h0, srcmac_q[47:32]};
      6'd4:    w_rd_val = srcmac_q[31:0];
      6'd5:    w_rd_val = dstip_q;
      6'd6:    w_rd_val = srcip_q;
      6'd7:    w_rd_val = {16'h0, dstport_q};
      6'd8:    w_rd_val = {16'h0, srcport_q};
      6'd9:    w_rd_val = ID_VALUE;
      default: w_rd_val = 32'h0;
    endcase
  end

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign w_merged = be_merge(w_rd_val, w_wdata, first_be_q);

  // Register next-state; offset 0x24 (ID) and unmapped offsets ignore writes.
  always_comb begin
    magic_d   = magic_q;
    dstmac_d  = dstmac_q;
    srcmac_d  = srcmac_q;
    dstip_d   = dstip_q;
    srcip_d   = srcip_q;
    dstport_d = dstport_q;
    srcport_d = srcport_q;
    if (w_wr_en) begin
      case (w_idx)
        6'd0:    magic_d          = w_merged;
        6'd1:    dstmac_d[47:32]  = w_merged[15:0];
        6'd2:    dstmac_d[31:0]   = w_merged;
        6'd3:    srcmac_d[47:32]  = w_merged[15:0];
        6'd4:    srcmac_d[31:0]   = w_merged;
        6'd5:    dstip_d          = w_merged;
        6'd6:    srcip_d          = w_merged;
        6'd7:    dstport_d        = w_merged[15:0];
        6'd8:    srcport_d        = w_merged[15:0];
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and TX outputs
  // --------------------------------------------------------------------------
  logic [31:0] w_cpl_dw0;
  logic [31:0] w_cpl_dw1;
  logic [31:0] w_cpl_dw2;

  // CplD header: fmt/type, TC and attr echoed, TD/EP clear, length 1.
  assign w_cpl_dw0 = {1'b0, FMT_3DW_DATA, TYPE_CPL, 1'b0, tc_q, 4'h0,
                      2'b00, attr_q, 2'b00, 10'd1};
  // Completer ID, status SC, BCM clear, byte count 4.
  assign w_cpl_dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number,
                      3'b000, 1'b0, 12'd4};
  assign w_cpl_dw2 = {req_id_q, tag_q, 1'b0, addr_lo_q};

  always_comb begin
    state_d          = state_q;
    s_axis_tx_req    = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    case (state_q)
      ST_IDLE: begin
        // A TLP that ends on beat 0 cannot be a supported request.
        if (w_rx_fire && !m_axis_rx_tlast) begin
          state_d = w_hdr_ok ? ST_HDR : ST_DROP;
        end
      end
      ST_HDR: begin
        if (w_rx_fire) begin
          if (!m_axis_rx_tlast) state_d = ST_DROP;
          else if (is_wr_q)     state_d = ST_IDLE;
          else                  state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (w_rx_fire && m_axis_rx_tlast) state_d = ST_IDLE;
      end
      ST_REQ: begin
        s_axis_tx_req = 1'b1;
        if (s_axis_tx_ack) state_d = ST_CPL0;
      end
      ST_CPL0: begin
        // Grant is only checked in REQ; losing ack here does not abort.
        s_axis_tx_req    = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tdata  = {w_cpl_dw1, w_cpl_dw0};
        s_axis_tx_tkeep  = {KEEP_WIDTH{1'b1}};
        if (s_axis_tx_tready) state_d = ST_CPL1;
      end
      ST_CPL1: begin
        s_axis_tx_req    = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tlast  = 1'b1;
        s_axis_tx_tdata  = {rdata_q, w_cpl_dw2};
        s_axis_tx_tkeep  = {KEEP_WIDTH{1'b1}};
        if (s_axis_tx_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axis_tx_tuser = 4'h0;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q    <= ST_IDLE;
      magic_q    <= '0;
      dstmac_q   <= '0;
      srcmac_q   <= '0;
      dstip_q    <= '0;
      srcip_q    <= '0;
      dstport_q  <= '0;
      srcport_q  <= '0;
      is_wr_q    <= 1'b0;
      tc_q       <= '0;
      attr_q     <= '0;
      req_id_q   <= '0;
      tag_q      <= '0;
      first_be_q <= '0;
      rdata_q    <= '0;
      addr_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      magic_q   <= magic_d;
      dstmac_q  <= dstmac_d;
      srcmac_q  <= srcmac_d;
      dstip_q   <= dstip_d;
      srcip_q   <= srcip_d;
      dstport_q <= dstport_d;
      srcport_q <= srcport_d;
      if (w_beat0) begin
        is_wr_q    <= w_is_mwr;
        tc_q       <= w_dw0[22:20];
        attr_q     <= w_dw0[13:12];
        req_id_q   <= w_dw1[31:16];
        tag_q      <= w_dw1[15:8];
        first_be_q <= w_dw1[3:0];
      end
      // Read data is sampled at decode; later writes do not alter the CplD.
      if (w_rd_cap) begin
        rdata_q   <= w_rd_val;
        addr_lo_q <= m_axis_rx_tdata[6:0];
      end
    end
  end

  assign adapter_reg_magic   = magic_q;
  assign adapter_reg_dstmac  = dstmac_q;
  assign adapter_reg_srcmac  = srcmac_q;
  assign adapter_reg_dstip   = dstip_q;
  assign adapter_reg_srcip   = srcip_q;
  assign adapter_reg_dstport = dstport_q;
  assign adapter_reg_srcport = srcport_q;

  // Stream bits with no function here (tkeep, other tuser bits, header
  // fields not needed for a 1-DW target).
  logic unused_ok;
  assign unused_ok = ^{m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tuser};

endmodule
`default_nettype wire

// File: tb/tb_nettlp_bar0_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_nettlp_bar0_regs
// Purpose  : Self-checking bench for nettlp_bar0_regs. Directed scenarios
//            followed by randomized MWr/MRd/malformed traffic, checked
//            against a field-level register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nettlp_bar0_regs;

  localparam logic [31:0] ID = 32'h4E54_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus = 8'd1;
  logic [4:0]  dev = 5'd0;
  logic [2:0]  func = 3'd0;
  logic [63:0] rx_tdata = '0;
  logic [7:0]  rx_tkeep = '0;
  logic        rx_tlast = 1'b0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [21:0] rx_tuser = '0;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic        tx_tready = 1'b0;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tvalid;
  logic [3:0]  tx_tuser;
  logic [31:0] r_magic, r_dstip, r_srcip;
  logic [47:0] r_dstmac, r_srcmac;
  logic [15:0] r_dstport, r_srcport;

  int n_vec = 0;
  int n_err = 0;

  nettlp_bar0_regs dut (
    .user_clk            (clk),
    .user_reset          (rst),
    .cfg_bus_number      (bus),
    .cfg_device_number   (dev),
    .cfg_function_number (func),
    .m_axis_rx_tdata     (rx_tdata),
    .m_axis_rx_tkeep     (rx_tkeep),
    .m_axis_rx_tlast     (rx_tlast),
    .m_axis_rx_tvalid    (rx_tvalid),
    .m_axis_rx_tready    (rx_tready),
    .m_axis_rx_tuser     (rx_tuser),
    .s_axis_tx_req       (tx_req),
    .s_axis_tx_ack       (tx_ack),
    .s_axis_tx_tready    (tx_tready),
    .s_axis_tx_tdata     (tx_tdata),
    .s_axis_tx_tkeep     (tx_tkeep),
    .s_axis_tx_tlast     (tx_tlast),
    .s_axis_tx_tvalid    (tx_tvalid),
    .s_axis_tx_tuser     (tx_tuser),
    .adapter_reg_magic   (r_magic),
    .adapter_reg_dstmac  (r_dstmac),
    .adapter_reg_srcmac  (r_srcmac),
    .adapter_reg_dstip   (r_dstip),
    .adapter_reg_srcip   (r_srcip),
    .adapter_reg_dstport (r_dstport),
    .adapter_reg_srcport (r_srcport)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (field level) ----------------
  logic [31:0] m_magic, m_dstip, m_srcip;
  logic [47:0] m_dstmac, m_srcmac;
  logic [15:0] m_dstport, m_srcport;

  task automatic m_reset();
    m_magic = '0; m_dstip = '0; m_srcip = '0;
    m_dstmac = '0; m_srcmac = '0; m_dstport = '0; m_srcport = '0;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        case (off)
          8'h00: m_magic[8*b +: 8] = d[8*b +: 8];
          8'h04: if (b < 2) m_dstmac[32+8*b +: 8] = d[8*b +: 8];
          8'h08: m_dstmac[8*b +: 8] = d[8*b +: 8];
          8'h0C: if (b < 2) m_srcmac[32+8*b +: 8] = d[8*b +: 8];
          8'h10: m_srcmac[8*b +: 8] = d[8*b +: 8];
          8'h14: m_dstip[8*b +: 8] = d[8*b +: 8];
          8'h18: m_srcip[8*b +: 8] = d[8*b +: 8];
          8'h1C: if (b < 2) m_dstport[8*b +: 8] = d[8*b +: 8];
          8'h20: if (b < 2) m_srcport[8*b +: 8] = d[8*b +: 8];
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:0] & 8'hFC)
      8'h00: return m_magic;
      8'h04: return {16'h0, m_dstmac[47:32]};
      8'h08: return m_dstmac[31:0];
      8'h0C: return {16'h0, m_srcmac[47:32]};
      8'h10: return m_srcmac[31:0];
      8'h14: return m_dstip;
      8'h18: return m_srcip;
      8'h1C: return {16'h0, m_dstport};
      8'h20: return {16'h0, m_srcport};
      8'h24: return ID;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".magic"},   64'(r_magic),   64'(m_magic));
    chk({tag, ".dstmac"},  64'(r_dstmac),  64'(m_dstmac));
    chk({tag, ".srcmac"},  64'(r_srcmac),  64'(m_srcmac));
    chk({tag, ".dstip"},   64'(r_dstip),   64'(m_dstip));
    chk({tag, ".srcip"},   64'(r_srcip),   64'(m_srcip));
    chk({tag, ".dstport"}, 64'(r_dstport), 64'(m_dstport));
    chk({tag, ".srcport"}, 64'(r_srcport), 64'(m_srcport));
  endtask

  function automatic logic [31:0] mk_dw0(input logic [1:0] fmt, input logic [4:0] typ,
                                         input logic [2:0] tc, input logic [1:0] attr,
                                         input logic [9:0] len);
    return {1'b0, fmt, typ, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, len};
  endfunction

  function automatic logic [31:0] mk_dw1(input logic [15:0] rid, input logic [7:0] tag,
                                         input logic [3:0] be);
    return {rid, tag, 4'h0, be};
  endfunction

  // Present one RX beat (called at a falling edge); returns at the falling
  // edge after the accepting rising edge.
  task automatic rx_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                         input logic bar);
    int n;
    n = 0;
    rx_tdata = d; rx_tkeep = k; rx_tlast = last;
    rx_tuser = {19'h0, bar, 2'b00}; rx_tvalid = 1'b1;
    while (rx_tready !== 1'b1 && n < 64) begin
      @(negedge clk); n++;
    end
    if (n >= 64) begin
      n_vec++; n_err++;
      $error("FAIL rx_timeout: observed tready=%b for %0d cycles expected 1", rx_tready, n);
    end
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    rx_beat({mk_dw1(16'h0100, 8'h00, be), mk_dw0(2'b10, 5'h00, 3'h0, 2'h0, 10'd1)},
            8'hFF, 1'b0, 1'b1);
    rx_beat({d, a}, 8'hFF, 1'b1, 1'b1);
    m_write(a, d, be);
    check_regs("wr");
    chk("wr_no_req", 64'(tx_req), 64'd0);
    chk("wr_no_tvalid", 64'(tx_tvalid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] tag, input logic [15:0] rid,
                         input logic [2:0] tc, input logic [1:0] attr,
                         input int ackdly, input int st0, input int st1);
    logic [63:0] e0, e1;
    e0 = {bus, dev, func, 3'b000, 1'b0, 12'd4,
          1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, 10'd1};
    e1 = {m_read(a), rid, tag, 1'b0, a[6:0]};
    rx_beat({mk_dw1(rid, tag, 4'hF), mk_dw0(2'b00, 5'h00, tc, attr, 10'd1)},
            8'hFF, 1'b0, 1'b1);
    rx_beat({32'h0, a}, 8'h0F, 1'b1, 1'b1);
    chk("rd_req_rise", 64'(tx_req), 64'd1);
    chk("rd_rx_bp", 64'(rx_tready), 64'd0);
    chk("rd_no_valid_before_ack", 64'(tx_tvalid), 64'd0);
    repeat (ackdly) begin
      @(negedge clk);
      chk("rd_req_hold", 64'(tx_req), 64'd1);
      chk("rd_wait_valid", 64'(tx_tvalid), 64'd0);
      chk("rd_wait_rx_bp", 64'(rx_tready), 64'd0);
    end
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("cpl0_valid", 64'(tx_tvalid), 64'd1);
    chk("cpl0_data", tx_tdata, e0);
    chk("cpl0_keep", 64'(tx_tkeep), 64'hFF);
    chk("cpl0_last", 64'(tx_tlast), 64'd0);
    repeat (st0) begin
      @(negedge clk);
      chk("cpl0_hold_data", tx_tdata, e0);
      chk("cpl0_hold_valid", 64'(tx_tvalid), 64'd1);
      chk("cpl0_rx_bp", 64'(rx_tready), 64'd0);
    end
    tx_tready = 1'b1;
    @(negedge clk);
    tx_tready = 1'b0;
    chk("cpl1_valid", 64'(tx_tvalid), 64'd1);
    chk("cpl1_data", tx_tdata, e1);
    chk("cpl1_keep", 64'(tx_tkeep), 64'hFF);
    chk("cpl1_last", 64'(tx_tlast), 64'd1);
    chk("cpl1_req", 64'(tx_req), 64'd1);
    repeat (st1) begin
      @(negedge clk);
      chk("cpl1_hold_data", tx_tdata, e1);
      chk("cpl1_rx_bp", 64'(rx_tready), 64'd0);
    end
    tx_tready = 1'b1;
    @(negedge clk);
    tx_tready = 1'b0;
    chk("cpl_done_req", 64'(tx_req), 64'd0);
    chk("cpl_done_valid", 64'(tx_tvalid), 64'd0);
    chk("cpl_done_rx_ready", 64'(rx_tready), 64'd1);
  endtask

  // Malformed or unsupported traffic: must be consumed with no effect.
  task automatic send_bad(input int kind, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] h1;
    h1 = mk_dw1(16'h0100, 8'h11, 4'hF);
    case (kind)
      0: begin // MWr length 2
        rx_beat({h1, mk_dw0(2'b10, 5'h00, 3'h0, 2'h0, 10'd2)}, 8'hFF, 1'b0, 1'b1);
        rx_beat({d, a}, 8'hFF, 1'b0, 1'b1);
        rx_beat({32'h0, ~d}, 8'h0F, 1'b1, 1'b1);
      end
      1: begin // MWr missing BAR0 hit
        rx_beat({h1, mk_dw0(2'b10, 5'h00, 3'h0, 2'h0, 10'd1)}, 8'hFF, 1'b0, 1'b0);
        rx_beat({d, a}, 8'hFF, 1'b1, 1'b0);
      end
      2: begin // 4DW MWr
        rx_beat({h1, mk_dw0(2'b11, 5'h00, 3'h0, 2'h0, 10'd1)}, 8'hFF, 1'b0, 1'b1);
        rx_beat({a, 32'h0}, 8'hFF, 1'b0, 1'b1);
        rx_beat({32'h0, d}, 8'h0F, 1'b1, 1'b1);
      end
      3: begin // MRd missing BAR0 hit
        rx_beat({h1, mk_dw0(2'b00, 5'h00, 3'h0, 2'h0, 10'd1)}, 8'hFF, 1'b0, 1'b0);
        rx_beat({32'h0, a}, 8'h0F, 1'b1, 1'b0);
      end
      4: begin // MWr header that ends on beat 0
        rx_beat({h1, mk_dw0(2'b10, 5'h00, 3'h0, 2'h0, 10'd1)}, 8'hFF, 1'b1, 1'b1);
      end
      default: begin // MRd length 2
        rx_beat({h1, mk_dw0(2'b00, 5'h00, 3'h0, 2'h0, 10'd2)}, 8'hFF, 1'b0, 1'b1);
        rx_beat({32'h0, a}, 8'h0F, 1'b1, 1'b1);
      end
    endcase
    repeat (3) begin
      @(negedge clk);
      chk("bad_no_req", 64'(tx_req), 64'd0);
      chk("bad_no_valid", 64'(tx_tvalid), 64'd0);
    end
    check_regs("bad");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d, t;
    int op;
    m_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rx_tready", 64'(rx_tready), 64'd0);
    chk("rst_req", 64'(tx_req), 64'd0);
    chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(tx_tlast), 64'd0);
    chk("rst_tdata", tx_tdata, 64'd0);
    chk("rst_tkeep", 64'(tx_tkeep), 64'd0);
    check_regs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_tready", 64'(rx_tready), 64'd1);
    chk("tx_tuser", 64'(tx_tuser), 64'd0);

    // Directed writes
    do_write(32'h0000_0014, 32'hC0A8_0A01, 4'hF);
    chk("dstip_value", 64'(r_dstip), 64'hC0A8_0A01);
    do_write(32'h0000_0008, 32'h1122_3344, 4'b0101);
    chk("dstmac_partial", 64'(r_dstmac), 64'h0000_0022_0044);

    // Directed reads: ID register, then long ack wait with tready stalls
    do_read(32'h0000_0024, 8'h5A, 16'h0100, 3'h0, 2'h0, 0, 0, 0);
    do_read(32'h0000_0014, 8'h33, 16'hBEEF, 3'h5, 2'h2, 10, 2, 1);

    // Unsupported traffic
    for (int k = 0; k < 6; k++) send_bad(k, 32'h0000_0000, 32'hDEAD_BEEF);

    // Randomized traffic
    bus = 8'hA5; dev = 5'h13; func = 3'h6;
    for (int i = 0; i < 60; i++) begin
      t = $urandom();
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = {t[31:8], 6'($urandom_range(16, 63)), 2'b00};
      else                           a = {t[31:8], 6'($urandom_range(0, 15)), 2'b00};
      d = $urandom();
      if (op <= 4)      do_write(a, d, 4'($urandom_range(0, 15)));
      else if (op <= 7) do_read(a, 8'($urandom()), 16'($urandom()), 3'($urandom()),
                                2'($urandom()), $urandom_range(0, 3),
                                $urandom_range(0, 2), $urandom_range(0, 2));
      else              send_bad($urandom_range(0, 5), {24'h0, a[7:0]}, d);
    end

    // Make sure registers are nonzero before the reset test
    do_write(32'h0000_0000, 32'hA5A5_5A5A, 4'hF);

    // Reset during CPL0 with tready low
    rx_beat({mk_dw1(16'h0100, 8'h77, 4'hF), mk_dw0(2'b00, 5'h00, 3'h0, 2'h0, 10'd1)},
            8'hFF, 1'b0, 1'b1);
    rx_beat({32'h0, 32'h0000_0000}, 8'h0F, 1'b1, 1'b1);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("prerst_cpl0_valid", 64'(tx_tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("midrst_tvalid", 64'(tx_tvalid), 64'd0);
    chk("midrst_req", 64'(tx_req), 64'd0);
    chk("midrst_rx_tready", 64'(rx_tready), 64'd0);
    check_regs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rx_tready", 64'(rx_tready), 64'd1);
    do_read(32'h0000_0024, 8'h5A, 16'h0100, 3'h0, 2'h0, 1, 1, 0);
    do_write(32'h0000_0020, 32'h1234_ABCD, 4'hF);
    do_read(32'h0000_0020, 8'h01, 16'h0200, 3'h1, 2'h1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
